// File: rtl/midi_tx_pkg.sv
// -----------------------------------------------------------------------------
// midi_tx_pkg
// Shared definitions for the MIDI note transmitter: payload width, status
// nibbles, the default baud rate and the state encodings of the message
// sequencer and the byte serializer.
// -----------------------------------------------------------------------------
package midi_tx_pkg;

   localparam int MIDI_PAYLOAD_BITS = 8;
   localparam int DEFAULT_BAUD      = 31250;

   localparam logic [3:0] NOTE_ON  = 4'b1001;
   localparam logic [3:0] NOTE_OFF = 4'b1000;

   // Message sequencer: one state per transmitted byte.
   typedef enum logic [1:0] {
      MSG_IDLE   = 2'd0,
      MSG_STATUS = 2'd1,
      MSG_NOTE   = 2'd2,
      MSG_VEL    = 2'd3
   } msg_state_e;

   // Byte serializer: one state per UART frame section.
   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

endpackage : midi_tx_pkg

// File: rtl/midi_tx_if.sv
// -----------------------------------------------------------------------------
// midi_tx_if
// Request/status bundle between a note source (master) and midi_tx (slave).
//   noteOnReq_i  : single-cycle Note On request
//   noteOffReq_i : single-cycle Note Off request (wins over Note On)
//   note_i       : note number, bit 7 ignored
//   velocity_i   : velocity, bit 7 ignored
//   ready_o      : a request is accepted this cycle
//   txDone_o     : pulse in the last clock of the final stop bit
// -----------------------------------------------------------------------------
interface midi_tx_if;
   import midi_tx_pkg::*;

   logic                         noteOnReq_i;
   logic                         noteOffReq_i;
   logic [MIDI_PAYLOAD_BITS-1:0] note_i;
   logic [MIDI_PAYLOAD_BITS-1:0] velocity_i;
   logic                         ready_o;
   logic                         txDone_o;

   modport master (
      output noteOnReq_i, noteOffReq_i, note_i, velocity_i,
      input  ready_o, txDone_o
   );

   modport slave (
      input  noteOnReq_i, noteOffReq_i, note_i, velocity_i,
      output ready_o, txDone_o
   );

endinterface : midi_tx_if

// File: rtl/midi_uart_tx.sv
// -----------------------------------------------------------------------------
// midi_uart_tx
// 8N1 serializer: start bit 0, eight data bits LSB first, stop bit 1, each bit
// CLKS_PER_BIT clocks long.
//   clk_i, nrst_i : clock, asynchronous active-low reset
//   byte_i        : byte to send, taken when valid_i and ready_o are both high
//   valid_i       : load request
//   ready_o       : high in IDLE and in the last clock of a stop bit, so a
//                   following byte starts with no idle gap
//   tx_o          : serial line, driven from a flop, idle high
//   done_o        : registered pulse in the last clock of each stop bit
// -----------------------------------------------------------------------------
module midi_uart_tx
   import midi_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 320
) (
   input  logic       clk_i,
   input  logic       nrst_i,
   input  logic [7:0] byte_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       done_o
);

   localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             last_s;

   assign last_s  = (cnt_q == CNT_MAX);
   assign ready_o = (state_q == UART_IDLE) || ((state_q == UART_STOP) && last_s);
   assign tx_o    = tx_q;
   assign done_o  = done_q;

   // Next-state logic for frame sequencing, bit timing and line level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      case (state_q)
         UART_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = 3'd0;
            if (valid_i) begin
               state_d = UART_START;
               sh_d    = byte_i;
               tx_d    = 1'b0;
            end else begin
               state_d = UART_IDLE;
               tx_d    = 1'b1;
            end
         end
         UART_START: begin
            if (last_s) begin
               cnt_d   = {CNT_W{1'b0}};
               idx_d   = 3'd0;
               state_d = UART_DATA;
               tx_d    = sh_q[0];
               sh_d    = {1'b0, sh_q[7:1]};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         UART_DATA: begin
            if (last_s) begin
               cnt_d = {CNT_W{1'b0}};
               if (idx_q == 3'd7) begin
                  state_d = UART_STOP;
                  tx_d    = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = sh_q[0];
                  sh_d  = {1'b0, sh_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         UART_STOP: begin
            if (last_s) begin
               cnt_d = {CNT_W{1'b0}};
               idx_d = 3'd0;
               // Chained byte: start bit directly after the stop bit.
               if (valid_i) begin
                  state_d = UART_START;
                  sh_d    = byte_i;
                  tx_d    = 1'b0;
               end else begin
                  state_d = UART_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = UART_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = 3'd0;
            tx_d    = 1'b1;
         end
      endcase
      // Look one cycle ahead so the registered pulse lines up with the
      // last clock of the stop bit.
      done_d = (state_d == UART_STOP) && (cnt_d == CNT_MAX);
   end

   // Serializer state registers; reset parks the line high.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= UART_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         idx_q   <= 3'd0;
         sh_q    <= 8'h00;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

endmodule : midi_uart_tx

// File: rtl/midi_tx.sv
// -----------------------------------------------------------------------------
// midi_tx
// Sends three-byte MIDI Note On / Note Off messages (status, note, velocity)
// over a 31250-baud style serial line. Owns message sequencing and byte
// selection only; serialization is done by midi_uart_tx.
//   clk_i  : system clock (CLK_FREQ Hz)
//   nrst_i : asynchronous active-low reset
//   bus    : request/status bundle (midi_tx_if.slave)
//   tx_o   : MIDI serial line, idle high
// -----------------------------------------------------------------------------
module midi_tx
   import midi_tx_pkg::*;
#(
   parameter int MIDI_CHANNEL = 0,
   parameter int CLK_FREQ     = 10_000_000,
   parameter int BAUD         = DEFAULT_BAUD
) (
   input  logic     clk_i,
   input  logic     nrst_i,
   midi_tx_if.slave bus,
   output logic     tx_o
);

   localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam logic [3:0] CHANNEL      = 4'(MIDI_CHANNEL);

   msg_state_e state_q, state_d;
   logic [7:0] note_q, note_d;
   logic [7:0] vel_q, vel_d;
   logic [7:0] byte_s;
   logic       valid_s;
   logic       uart_ready_s;
   logic       uart_done_s;
   logic       accept_s;
   logic       unused_s;

   // Bit 7 of the payload inputs is deliberately discarded.
   assign unused_s = ^{bus.note_i[7], bus.velocity_i[7]};

   assign accept_s     = (state_q == MSG_IDLE) && (bus.noteOnReq_i || bus.noteOffReq_i);
   assign bus.ready_o  = (state_q == MSG_IDLE);
   // Both operands are flops; the pulse marks the final velocity stop clock.
   assign bus.txDone_o = (state_q == MSG_VEL) && uart_done_s;

   // Message sequencing and byte selection for the serializer.
   always_comb begin
      state_d = state_q;
      note_d  = note_q;
      vel_d   = vel_q;
      byte_s  = 8'h00;
      valid_s = 1'b0;
      case (state_q)
         MSG_IDLE: begin
            if (accept_s) begin
               // Note Off has priority when both requests arrive together.
               byte_s  = {(bus.noteOffReq_i ? NOTE_OFF : NOTE_ON), CHANNEL};
               valid_s = 1'b1;
               note_d  = {1'b0, bus.note_i[6:0]};
               vel_d   = {1'b0, bus.velocity_i[6:0]};
               state_d = MSG_STATUS;
            end else begin
               state_d = MSG_IDLE;
            end
         end
         MSG_STATUS: begin
            if (uart_ready_s) begin
               byte_s  = note_q;
               valid_s = 1'b1;
               state_d = MSG_NOTE;
            end else begin
               state_d = MSG_STATUS;
            end
         end
         MSG_NOTE: begin
            if (uart_ready_s) begin
               byte_s  = vel_q;
               valid_s = 1'b1;
               state_d = MSG_VEL;
            end else begin
               state_d = MSG_NOTE;
            end
         end
         MSG_VEL: begin
            if (uart_ready_s) begin
               state_d = MSG_IDLE;
            end else begin
               state_d = MSG_VEL;
            end
         end
         default: begin
            state_d = MSG_IDLE;
         end
      endcase
   end

   // Sequencer state and latched payload.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= MSG_IDLE;
         note_q  <= 8'h00;
         vel_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         note_q  <= note_d;
         vel_q   <= vel_d;
      end
   end

   midi_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clk_i   (clk_i),
      .nrst_i  (nrst_i),
      .byte_i  (byte_s),
      .valid_i (valid_s),
      .ready_o (uart_ready_s),
      .tx_o    (tx_o),
      .done_o  (uart_done_s)
   );

endmodule : midi_tx

// File: tb/tb_midi_tx.sv
// -----------------------------------------------------------------------------
// tb_midi_tx
// Two midi_tx instances (channel 0 and channel 5, 10 clocks per bit) receive
// identical requests; each message is decoded from both serial lines and the
// line is compared clock by clock against the ideal 8N1 waveform.
// -----------------------------------------------------------------------------
module tb_midi_tx;
   import midi_tx_pkg::*;

   typedef struct {
      bit         on;
      bit         off;
      logic [7:0] note;
      logic [7:0] vel;
      logic [23:0] exp0;
      logic [23:0] exp5;
   } vec_t;

   logic clk;
   logic nrst;
   logic tx0, tx5;
   int   n_checks;
   int   n_fail;

   midi_tx_if bus0 ();
   midi_tx_if bus5 ();

   midi_tx #(.MIDI_CHANNEL(0), .CLK_FREQ(312500), .BAUD(31250)) u_dut0 (
      .clk_i (clk), .nrst_i (nrst), .bus (bus0.slave), .tx_o (tx0)
   );

   midi_tx #(.MIDI_CHANNEL(5), .CLK_FREQ(312500), .BAUD(31250)) u_dut5 (
      .clk_i (clk), .nrst_i (nrst), .bus (bus5.slave), .tx_o (tx5)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input bit on, input bit off, input logic [7:0] note, input logic [7:0] vel);
      bus0.noteOnReq_i  = on;
      bus0.noteOffReq_i = off;
      bus0.note_i       = note;
      bus0.velocity_i   = vel;
      bus5.noteOnReq_i  = on;
      bus5.noteOffReq_i = off;
      bus5.note_i       = note;
      bus5.velocity_i   = vel;
   endtask

   // Ideal line level k clocks after acceptance (10 clocks/bit, 10 bits/frame).
   function automatic logic exp_bit(input logic [23:0] msg, input int k);
      int f;
      int b;
      logic [7:0] by;
      f  = k / 100;
      b  = (k % 100) / 10;
      by = msg[23 - 8*f -: 8];
      if (b == 0) return 1'b0;
      else if (b == 9) return 1'b1;
      else return by[b-1];
   endfunction

   // Issues a request at the current negedge and follows the message for
   // 301 clocks; optionally injects a second request at clock inject_at.
   // Returns at the negedge of clock 300 (ready high again).
   task automatic run_msg(input vec_t v, input int inject_at, input string tag);
      logic [23:0] got0, got5;
      int werr0, werr5, d0, d5, dpos_bad, rdy_bad;
      got0 = 24'h0; got5 = 24'h0;
      werr0 = 0; werr5 = 0; d0 = 0; d5 = 0; dpos_bad = 0; rdy_bad = 0;
      set_req(v.on, v.off, v.note, v.vel);
      @(posedge clk);
      #1;
      // Scrambled inputs after acceptance must not reach the line.
      set_req(1'b0, 1'b0, 8'hEE, 8'hEE);
      for (int k = 0; k <= 300; k++) begin
         @(negedge clk);
         if (k == inject_at) set_req(1'b1, 1'b0, 8'h11, 8'h22);
         else if (k == inject_at + 1) set_req(1'b0, 1'b0, 8'hEE, 8'hEE);
         if (k < 300) begin
            if (tx0 !== exp_bit(v.exp0, k)) werr0++;
            if (tx5 !== exp_bit(v.exp5, k)) werr5++;
            if ((k % 10) == 5 && ((k % 100) / 10) >= 1 && ((k % 100) / 10) <= 8) begin
               got0[16 - 8*(k/100) + ((k % 100) / 10) - 1] = tx0;
               got5[16 - 8*(k/100) + ((k % 100) / 10) - 1] = tx5;
            end
            if (bus0.txDone_o === 1'b1) begin d0++; if (k != 299) dpos_bad++; end
            if (bus5.txDone_o === 1'b1) begin d5++; if (k != 299) dpos_bad++; end
            if (bus0.ready_o !== 1'b0 || bus5.ready_o !== 1'b0) rdy_bad++;
         end
      end
      check({tag, " bytes ch0"}, {8'h00, got0}, {8'h00, v.exp0});
      check({tag, " bytes ch5"}, {8'h00, got5}, {8'h00, v.exp5});
      check({tag, " waveform errs ch0"}, werr0, 0);
      check({tag, " waveform errs ch5"}, werr5, 0);
      check({tag, " txDone pulses ch0"}, d0, 1);
      check({tag, " txDone pulses ch5"}, d5, 1);
      check({tag, " txDone position"}, dpos_bad, 0);
      check({tag, " ready low in msg"}, rdy_bad, 0);
      check({tag, " idle tx after"}, {30'h0, tx0, tx5}, 32'h3);
      check({tag, " ready after"}, {30'h0, bus0.ready_o, bus5.ready_o}, 32'h3);
      check({tag, " txDone after"}, {30'h0, bus0.txDone_o, bus5.txDone_o}, 32'h0);
   endtask

   // Counts clocks where either line is low or ready drops while idle.
   task automatic idle_watch(input int n, input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || tx5 !== 1'b1 || bus0.ready_o !== 1'b1 || bus5.ready_o !== 1'b1) bad++;
      end
      check({tag, " quiet idle"}, bad, 0);
   endtask

   vec_t vecs [6];

   initial begin
      vec_t v;
      n_checks = 0;
      n_fail   = 0;
      vecs[0] = '{1'b1, 1'b0, 8'h3C, 8'h64, 24'h903C64, 24'h953C64};
      vecs[1] = '{1'b0, 1'b1, 8'hBC, 8'hFF, 24'h803C7F, 24'h853C7F};
      vecs[2] = '{1'b1, 1'b1, 8'h12, 8'h34, 24'h801234, 24'h851234};
      vecs[3] = '{1'b1, 1'b0, 8'h7F, 8'h00, 24'h907F00, 24'h957F00};
      vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h80, 24'h900000, 24'h950000};
      vecs[5] = '{1'b0, 1'b1, 8'h55, 8'hAA, 24'h80552A, 24'h85552A};

      // Reset state.
      nrst = 1'b0;
      set_req(1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      check("reset tx", {30'h0, tx0, tx5}, 32'h3);
      check("reset ready", {30'h0, bus0.ready_o, bus5.ready_o}, 32'h3);
      check("reset txDone", {30'h0, bus0.txDone_o, bus5.txDone_o}, 32'h0);
      nrst = 1'b1;
      idle_watch(3, "post reset");

      // Table-driven messages with idle gaps.
      for (int i = 0; i < 6; i++) begin
         run_msg(vecs[i], -1, $sformatf("vec%0d", i));
         idle_watch(3, $sformatf("vec%0d", i));
      end

      // Back-to-back: second request on the first ready cycle, so exactly
      // one idle-high clock precedes its start bit.
      run_msg(vecs[0], -1, "b2b first");
      run_msg(vecs[5], -1, "b2b second");
      idle_watch(3, "b2b");

      // Request at clock 100 of a message is dropped.
      run_msg(vecs[3], 100, "drop");
      idle_watch(20, "drop");

      // Reset at clock 150 aborts the message.
      set_req(1'b1, 1'b0, 8'h0F, 8'h40);
      @(posedge clk);
      #1;
      set_req(1'b0, 1'b0, 8'h00, 8'h00);
      for (int k = 0; k <= 150; k++) @(negedge clk);
      check("pre-abort tx low", {30'h0, tx0, tx5}, 32'h0);
      nrst = 1'b0;
      #1;
      check("abort tx", {30'h0, tx0, tx5}, 32'h3);
      check("abort ready", {30'h0, bus0.ready_o, bus5.ready_o}, 32'h3);
      check("abort txDone", {30'h0, bus0.txDone_o, bus5.txDone_o}, 32'h0);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      idle_watch(20, "after abort");
      v = '{1'b0, 1'b1, 8'h40, 8'h01, 24'h804001, 24'h854001};
      run_msg(v, -1, "after abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_midi_tx

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 Parameter MIDI_CHANNEL, default 0, sets the 4-bit channel nibble in every status byte.
REQ-002 Parameter CLK_FREQ, default 10_000_000, is the clk_i frequency in Hz.
REQ-003 Parameter BAUD, default 31250, is the serial bit rate; localparam CLKS_PER_BIT = CLK_FREQ/BAUD, integer division.
REQ-004 clk_i  in  1  system clock; all logic is on the rising edge.
REQ-005 nrst_i  in  1  asynchronous, active-low reset.
REQ-006 noteOnReq_i  in  1  single-cycle request to send Note On.
REQ-007 noteOffReq_i  in  1  single-cycle request to send Note Off.
REQ-008 note_i  in  `MIDI_PAYLOAD_BITS  note number; bit 7 is ignored.
REQ-009 velocity_i  in  `MIDI_PAYLOAD_BITS  velocity; bit 7 is ignored.
REQ-010 ready_o  out  1  high when a request will be accepted this cycle.
REQ-011 txDone_o  out  1  one-cycle pulse when the last stop bit of a message completes.
REQ-012 tx_o  out  1  MIDI serial line, idle high.

Function
REQ-013 A request is accepted on a rising edge where ready_o=1 and either request input is 1; requests while ready_o=0 are dropped, with no queueing.
REQ-014 If noteOnReq_i and noteOffReq_i are both 1 at acceptance, Note Off is sent and Note On is dropped.
REQ-015 Acceptance latches {0x9 or 0x8, MIDI_CHANNEL[3:0]}, {0, note_i[6:0]} and {0, velocity_i[6:0]}; later input changes do not affect the message in flight.
REQ-016 Message FSM states: IDLE -> STATUS -> NOTE -> VEL -> IDLE; each non-IDLE state lasts exactly one UART frame.
REQ-017 ready_o = 1 only in IDLE; it is combinational from state.
REQ-018 UART frame: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly CLKS_PER_BIT clocks.
REQ-019 tx_o drives the start bit of the status byte from the edge after acceptance; there is no idle gap between the three frames.
REQ-020 A full message occupies 30*CLKS_PER_BIT clocks of tx_o.
REQ-021 txDone_o pulses in the last clock of the velocity stop bit.
REQ-022 ready_o rises in the cycle after that pulse, so back-to-back messages have at least one idle-high clock between them.
REQ-023 No running status: every message sends all three bytes.
REQ-024 The bit-timing counter spans 0..CLKS_PER_BIT-1 and wraps; its width is $clog2(CLKS_PER_BIT).
REQ-025 The data-bit index spans 0..7.
REQ-026 tx_o is driven from a flop (glitch-free).

Reset
REQ-027 nrst_i low forces tx_o=1, ready_o=1, txDone_o=0, FSMs to IDLE and counters to 0, immediately and asynchronously.
REQ-028 Reset mid-frame aborts the message; no partial byte resumes after release.
REQ-029 The first accepted request after release starts a clean frame.

Structure
REQ-030 MIDI_PAYLOAD_BITS, the status nibbles (NOTE_ON=4'b1001, NOTE_OFF=4'b1000) and the default BAUD live in the shared global include.
REQ-031 Byte serialization is a sub-module midi_uart_tx.
REQ-032 midi_uart_tx has ports: byte-in, valid-in, ready-out, tx-out, and a frame-done pulse.
REQ-033 midi_uart_tx has states IDLE, START, DATA and STOP.
REQ-034 midi_tx owns only message sequencing and byte selection.

Verification
REQ-035 Scenario 1: CLK_FREQ=312500 (10 clk/bit), MIDI_CHANNEL=0. Note On request with note 0x3C and velocity 0x64 -> tx_o carries 0x90, 0x3C, 0x64; 300 clocks; one txDone_o pulse; then ready_o=1.
REQ-036 Scenario 2: MIDI_CHANNEL=5. Note Off request with note 0xBC and velocity 0xFF -> bytes 0x85, 0x3C, 0x7F.
REQ-037 Scenario 3: noteOnReq_i and noteOffReq_i asserted in the same cycle -> only the 0x8n message is sent.
REQ-038 Scenario 4: a second request at clock 100 of a message -> it is ignored and exactly 30 frame bits are observed.
REQ-039 Scenario 5: nrst_i asserted at clock 150 of a message -> tx_o=1 and ready_o=1 the same cycle. A new request after release -> a complete, correct message.
REQ-040 Scenario 6: a request issued the cycle ready_o returns high after txDone_o -> the new start bit follows with exactly one idle-high clock, and a UART checker decodes both messages error-free.
